// File: rtl/fb_rect_fill.sv
// Rectangle-fill write engine: turns one corner-pair command into a raster of
// packed framebuffer writes (color[18:16], column[13:8], row[5:0]), one per clock.
module fb_rect_fill #(
    parameter int unsigned MAX_X = 39,
    parameter int unsigned MAX_Y = 29
) (
    input  logic        clka,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_x0,
    input  logic [5:0]  cmd_y0,
    input  logic [5:0]  cmd_x1,
    input  logic [5:0]  cmd_y1,
    input  logic [2:0]  cmd_color,
    output logic [31:0] fb_din,
    output logic        fb_we,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW   = 6;
    localparam int unsigned COLW = 3;
    localparam int unsigned DW   = 32;
    localparam logic [CW-1:0] MAX_XC = CW'(MAX_X);
    localparam logic [CW-1:0] MAX_YC = CW'(MAX_Y);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   x0_q, y0_q, x1_q, y1_q;
    logic [CW-1:0]   x0_nx, y0_nx, x1_nx, y1_nx;
    logic [COLW-1:0] color_q, color_nx;
    logic [CW-1:0]   xl_q, xh_q, yl_q, yh_q;
    logic [CW-1:0]   xl_nx, xh_nx, yl_nx, yh_nx;
    logic [CW-1:0]   cx_q, cy_q, cx_nx, cy_nx;
    logic [DW-1:0]   fb_din_nx;
    logic            fb_we_nx, busy_nx, done_nx, cmd_ready_nx;
    logic            accept;

    // Ordered and clipped bounds derived from the captured corners.
    logic [CW-1:0]   lo_x, hi_x, lo_y, hi_y, clip_x, clip_y;

    always_comb begin
        lo_x   = (x0_q < x1_q) ? x0_q : x1_q;
        hi_x   = (x0_q < x1_q) ? x1_q : x0_q;
        lo_y   = (y0_q < y1_q) ? y0_q : y1_q;
        hi_y   = (y0_q < y1_q) ? y1_q : y0_q;
        clip_x = (hi_x > MAX_XC) ? MAX_XC : hi_x;
        clip_y = (hi_y > MAX_YC) ? MAX_YC : hi_y;
    end

    assign accept = cmd_valid & cmd_ready;

    // Next-state and registered-output logic.
    always_comb begin
        state_nx  = state;
        x0_nx     = x0_q;
        y0_nx     = y0_q;
        x1_nx     = x1_q;
        y1_nx     = y1_q;
        color_nx  = color_q;
        xl_nx     = xl_q;
        xh_nx     = xh_q;
        yl_nx     = yl_q;
        yh_nx     = yh_q;
        cx_nx     = cx_q;
        cy_nx     = cy_q;
        fb_din_nx = fb_din;
        fb_we_nx  = 1'b0;
        done_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    x0_nx    = cmd_x0;
                    y0_nx    = cmd_y0;
                    x1_nx    = cmd_x1;
                    y1_nx    = cmd_y1;
                    color_nx = cmd_color;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                xl_nx = lo_x;
                xh_nx = clip_x;
                yl_nx = lo_y;
                yh_nx = clip_y;
                if ((lo_x > MAX_XC) || (lo_y > MAX_YC)) begin
                    state_nx = DONE;
                end else begin
                    cx_nx    = lo_x;
                    cy_nx    = lo_y;
                    state_nx = FILL;
                end
            end
            FILL: begin
                fb_we_nx  = 1'b1;
                fb_din_nx = {13'b0, color_q, 2'b0, cx_q, 2'b0, cy_q};
                if (cx_q == xh_q) begin
                    if (cy_q == yh_q) begin
                        state_nx = DONE;
                    end else begin
                        cx_nx = xl_q;
                        cy_nx = CW'(cy_q + 1'b1);
                    end
                end else begin
                    cx_nx = CW'(cx_q + 1'b1);
                end
            end
            DONE: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // busy spans handshake through the done pulse; ready is its complement.
        busy_nx      = (state != IDLE) || accept;
        cmd_ready_nx = ~busy_nx;
    end

    always_ff @(posedge clka) begin
        if (!reset) begin
            state     <= IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            color_q   <= '0;
            xl_q      <= '0;
            xh_q      <= '0;
            yl_q      <= '0;
            yh_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            fb_din    <= '0;
            fb_we     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_nx;
            x0_q      <= x0_nx;
            y0_q      <= y0_nx;
            x1_q      <= x1_nx;
            y1_q      <= y1_nx;
            color_q   <= color_nx;
            xl_q      <= xl_nx;
            xh_q      <= xh_nx;
            yl_q      <= yl_nx;
            yh_q      <= yh_nx;
            cx_q      <= cx_nx;
            cy_q      <= cy_nx;
            fb_din    <= fb_din_nx;
            fb_we     <= fb_we_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            cmd_ready <= cmd_ready_nx;
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed self-checking bench for fb_rect_fill: hand-computed write words,
// latency, clipping, full-screen coverage, reset abort and handshake holding.
module tb_fb_rect_fill;

    logic        clka = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [2:0]  cmd_color;
    logic [31:0] fb_din;
    logic        fb_we;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    logic [31:0] wq[$];

    fb_rect_fill dut (
        .clka      (clka),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .fb_din    (fb_din),
        .fb_we     (fb_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clka = ~clka;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for ready, then presents a command for exactly one accepting edge.
    task automatic send(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                        input logic [5:0] d, input logic [2:0] col);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 100) begin
            @(negedge clka);
            k++;
        end
        check("ready_wait", {31'b0, cmd_ready}, 32'd1);
        cmd_x0 = a; cmd_y0 = b; cmd_x1 = c; cmd_y1 = d; cmd_color = col;
        cmd_valid = 1'b1;
        @(posedge clka);
        #1 cmd_valid = 1'b0;
    endtask

    // Collects writes after a handshake; k counts negedges after the accepting edge.
    task automatic collect(output int n, output int done_k, output int first_k, output int last_k);
        n = 0; done_k = -1; first_k = -1; last_k = -1;
        wq.delete();
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clka);
            if (fb_we) begin
                wq.push_back(fb_din);
                n++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    int n, dk, fk, lk, bad, once, ndone;
    int hits[64][64];
    logic [31:0] exp_sw[6];
    logic [31:0] exp_hs[6];

    initial begin
        reset = 1'b0; cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
        repeat (3) @(posedge clka);
        @(negedge clka);
        check("rst_we", {31'b0, fb_we}, 32'd0);
        check("rst_din", fb_din, 32'd0);
        check("rst_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clka);

        // Single pixel with cycle-exact latency.
        send(6'd5, 6'd7, 6'd5, 6'd7, 3'b101);
        @(negedge clka);
        check("sp_k1_we", {31'b0, fb_we}, 32'd0);
        check("sp_k1_busy", {31'b0, busy}, 32'd1);
        check("sp_k1_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clka);
        check("sp_k2_we", {31'b0, fb_we}, 32'd0);
        @(negedge clka);
        check("sp_k3_we", {31'b0, fb_we}, 32'd1);
        check("sp_k3_din", fb_din, 32'h0005_0507);
        check("sp_k3_done", {31'b0, done}, 32'd0);
        @(negedge clka);
        check("sp_k4_we", {31'b0, fb_we}, 32'd0);
        check("sp_k4_done", {31'b0, done}, 32'd1);
        check("sp_k4_busy", {31'b0, busy}, 32'd1);
        check("sp_k4_ready", {31'b0, cmd_ready}, 32'd0);
        check("sp_k4_hold", fb_din, 32'h0005_0507);
        @(negedge clka);
        check("sp_k5_done", {31'b0, done}, 32'd0);
        check("sp_k5_ready", {31'b0, cmd_ready}, 32'd1);
        check("sp_k5_busy", {31'b0, busy}, 32'd0);

        // Swapped corners, then the same rectangle with ordered corners.
        exp_sw = '{32'h0002_0803, 32'h0002_0903, 32'h0002_0A03,
                   32'h0002_0804, 32'h0002_0904, 32'h0002_0A04};
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) send(6'd10, 6'd4, 6'd8, 6'd3, 3'd2);
            else           send(6'd8, 6'd3, 6'd10, 6'd4, 3'd2);
            collect(n, dk, fk, lk);
            check($sformatf("sw%0d_count", pass), n, 32'd6);
            check($sformatf("sw%0d_first", pass), fk, 32'd3);
            check($sformatf("sw%0d_span", pass), lk - fk + 1, 32'd6);
            check($sformatf("sw%0d_done", pass), dk, 32'd9);
            for (int i = 0; i < 6; i++)
                check($sformatf("sw%0d_w%0d", pass, i), (i < wq.size()) ? wq[i] : 32'hDEAD_BEEF, exp_sw[i]);
        end

        // Partial clip at the bottom-right corner.
        send(6'd38, 6'd28, 6'd63, 6'd63, 3'd1);
        collect(n, dk, fk, lk);
        check("clip_count", n, 32'd4);
        check("clip_w0", (wq.size() > 0) ? wq[0] : 32'hDEAD_BEEF, 32'h0001_261C);
        check("clip_w1", (wq.size() > 1) ? wq[1] : 32'hDEAD_BEEF, 32'h0001_271C);
        check("clip_w2", (wq.size() > 2) ? wq[2] : 32'hDEAD_BEEF, 32'h0001_261D);
        check("clip_w3", (wq.size() > 3) ? wq[3] : 32'hDEAD_BEEF, 32'h0001_271D);

        // Fully off-screen: no writes, done two edges after the handshake.
        send(6'd45, 6'd0, 6'd50, 6'd5, 3'd3);
        collect(n, dk, fk, lk);
        check("off_count", n, 32'd0);
        check("off_done", dk, 32'd3);

        // Full screen scoreboard.
        send(6'd0, 6'd0, 6'd39, 6'd29, 3'd7);
        collect(n, dk, fk, lk);
        check("full_count", n, 32'd1200);
        check("full_first", fk, 32'd3);
        check("full_span", lk - fk + 1, 32'd1200);
        check("full_done", dk, 32'd1203);
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 64; y++) hits[x][y] = 0;
        bad = 0;
        foreach (wq[i]) begin
            if (wq[i][31:16] != 16'h0007 || wq[i][15:14] != 2'b00 || wq[i][7:6] != 2'b00) bad++;
            hits[wq[i][13:8]][wq[i][5:0]]++;
        end
        once = 0;
        for (int x = 0; x < 40; x++)
            for (int y = 0; y < 30; y++)
                if (hits[x][y] == 1) once++;
        check("full_bad_words", bad, 32'd0);
        check("full_each_once", once, 32'd1200);
        check("full_w_first", (wq.size() > 0) ? wq[0] : 32'hDEAD_BEEF, 32'h0007_0000);
        check("full_w_last", (wq.size() > 0) ? wq[wq.size()-1] : 32'hDEAD_BEEF, 32'h0007_271D);

        // cmd_valid held high with fields changing during busy.
        exp_hs = '{32'h0004_0101, 32'h0004_0201, 32'h0006_1414,
                   32'h0006_1514, 32'h0006_1415, 32'h0006_1515};
        send(6'd1, 6'd1, 6'd2, 6'd1, 3'd4);
        cmd_valid = 1'b1;
        cmd_x0 = 6'd20; cmd_y0 = 6'd20; cmd_x1 = 6'd21; cmd_y1 = 6'd21; cmd_color = 3'd6;
        wq.delete();
        ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clka);
            if (fb_we) wq.push_back(fb_din);
            if (done) ndone++;
            if (k == 6) check("hs_ready_k6", {31'b0, cmd_ready}, 32'd1);
            if (k == 7) begin
                cmd_x0 = 6'd0; cmd_y0 = 6'd0; cmd_x1 = 6'd39; cmd_y1 = 6'd29; cmd_color = 3'd1;
            end
            if (k == 9) cmd_valid = 1'b0;
        end
        check("hs_count", wq.size(), 32'd6);
        check("hs_dones", ndone, 32'd2);
        for (int i = 0; i < 6; i++)
            check($sformatf("hs_w%0d", i), (i < wq.size()) ? wq[i] : 32'hDEAD_BEEF, exp_hs[i]);

        // Reset in the middle of a full-screen fill abandons it.
        send(6'd0, 6'd0, 6'd39, 6'd29, 3'd7);
        repeat (20) @(negedge clka);
        check("mid_we", {31'b0, fb_we}, 32'd1);
        reset = 1'b0;
        @(negedge clka);
        check("mr_we", {31'b0, fb_we}, 32'd0);
        check("mr_ready", {31'b0, cmd_ready}, 32'd1);
        check("mr_done", {31'b0, done}, 32'd0);
        check("mr_busy", {31'b0, busy}, 32'd0);
        check("mr_din", fb_din, 32'd0);
        repeat (2) @(negedge clka);
        reset = 1'b1;
        n = 0; ndone = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clka);
            if (fb_we) n++;
            if (done) ndone++;
        end
        check("post_rst_writes", n, 32'd0);
        check("post_rst_done", ndone, 32'd0);
        check("post_rst_ready", {31'b0, cmd_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
